// File: rtl/uart_rx_if.sv
// AXI4-Stream byte channel carrying received UART data to the downstream consumer.
interface uart_rx_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_WIDTH data bits LSB-first, 1 stop; one bit = prescale*8 clk cycles.
// Good bytes are held in a single-word AXI4-Stream output register.
module uart_rx #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   uart_rx_if.master   m_axis,
   input  logic        rxd,
   output logic        busy,
   output logic        overrun_error,
   output logic        frame_error,
   input  logic [15:0] prescale
);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e                state_q, state_d;
   logic                  rxd_meta_q, rxd_s_q, rxd_prev_q;
   logic [2:0]            fill_q;
   logic [18:0]           cnt_q, cnt_d;
   logic [15:0]           p_q, p_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  overrun_q, overrun_d;
   logic                  frame_q, frame_d;
   logic [15:0]           p_in;
   logic [18:0]           half_start, bit_period;
   logic                  start_edge;

   assign p_in       = (prescale == 16'd0) ? 16'd1 : prescale;
   assign half_start = {1'b0, p_in, 2'b00} - 19'd1;
   assign bit_period = {p_q, 3'b000} - 19'd1;
   // fill_q[2] is set once rxd_prev_q holds a real pin sample, so a line held low
   // across reset release is never mistaken for a start edge.
   assign start_edge = fill_q[2] & rxd_prev_q & ~rxd_s_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
         fill_q     <= 3'b000;
         state_q    <= StIdle;
         cnt_q      <= '0;
         p_q        <= 16'd1;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         overrun_q  <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q;
         fill_q     <= {fill_q[1:0], 1'b1};
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         p_q        <= p_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         overrun_q  <= overrun_d;
         frame_q    <= frame_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      overrun_d = 1'b0;
      frame_d   = 1'b0;

      if (tvalid_q && m_axis.tready) begin
         tvalid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               p_d     = p_in;
               cnt_d   = half_start;
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == '0) begin
               if (!rxd_s_q) begin
                  cnt_d     = bit_period;
                  bit_cnt_d = 4'(DATA_WIDTH);
                  state_d   = StData;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         StData: begin
            if (cnt_q == '0) begin
               shift_d   = {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
               cnt_d     = bit_period;
               bit_cnt_d = bit_cnt_q - 4'd1;
               if (bit_cnt_q == 4'd1) begin
                  state_d = StStop;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         StStop: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               if (rxd_s_q) begin
                  // A same-cycle handshake frees the register for the new byte.
                  if (!tvalid_q || m_axis.tready) begin
                     tdata_d  = shift_q;
                     tvalid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign busy          = (state_q != StIdle);
   assign overrun_error = overrun_q;
   assign frame_error   = frame_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven from the bench, received bytes logged.
module tb_uart_rx;

   logic        clk;
   logic        rst_n;
   logic        rxd;
   logic        busy;
   logic        overrun_error;
   logic        frame_error;
   logic [15:0] prescale;

   uart_rx_if #(.DATA_WIDTH(8)) axis ();

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m_axis        (axis.master),
      .rxd           (rxd),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error),
      .prescale      (prescale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q[$];
   int         hs_cyc = 0;
   int         ovr_cnt = 0;
   int         frm_cnt = 0;
   int         busy_rise = 0;
   logic       busy_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (axis.tvalid && axis.tready) begin
            rx_q.push_back(axis.tdata);
            hs_cyc = cyc;
         end
         if (overrun_error) ovr_cnt = ovr_cnt + 1;
         if (frame_error)   frm_cnt = frm_cnt + 1;
         if (busy && !busy_prev) busy_rise = busy_rise + 1;
         busy_prev = busy;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   int t_start;

   // Drives one frame; returns while the stop bit is still on the line.
   task automatic send_byte(input logic [7:0] b, input logic stop, input int p);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         rxd = fr[i];
         if (i == 0) t_start = cyc;
         repeat (8 * p - 1) @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [7:0] loop_bytes[4];
   int         base_q, base_ovr, base_frm, base_busy;

   initial begin
      loop_bytes[0] = 8'h00;
      loop_bytes[1] = 8'hFF;
      loop_bytes[2] = 8'h55;
      loop_bytes[3] = 8'h3C;
      rst_n       = 1'b0;
      rxd         = 1'b1;
      prescale    = 16'd1;
      axis.tready = 1'b1;
      idle(3);
      check_eq("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
      check_eq("rst_tdata", {24'd0, axis.tdata}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_overrun", {31'd0, overrun_error}, 32'd0);
      check_eq("rst_frame", {31'd0, frame_error}, 32'd0);
      rst_n = 1'b1;
      idle(10);

      // Single frame at prescale=1, latency = 2 sync + 1 detect + 76P.
      base_q = rx_q.size(); base_ovr = ovr_cnt; base_frm = frm_cnt;
      send_byte(8'hA5, 1'b1, 1);
      idle(20);
      check_eq("a5_count", rx_q.size() - base_q, 32'd1);
      if (rx_q.size() > base_q) check_eq("a5_data", {24'd0, rx_q[base_q]}, 32'hA5);
      check_eq("a5_latency", hs_cyc - t_start, 32'd79);
      check_eq("a5_overrun", ovr_cnt - base_ovr, 32'd0);
      check_eq("a5_frame", frm_cnt - base_frm, 32'd0);

      // Back-to-back frames at prescale=2.
      prescale = 16'd2;
      base_q = rx_q.size(); base_ovr = ovr_cnt; base_frm = frm_cnt;
      for (int i = 0; i < 4; i++) send_byte(loop_bytes[i], 1'b1, 2);
      idle(40);
      check_eq("b2b_count", rx_q.size() - base_q, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (rx_q.size() > base_q + i)
            check_eq($sformatf("b2b_data%0d", i), {24'd0, rx_q[base_q+i]},
                     {24'd0, loop_bytes[i]});
      end
      check_eq("b2b_errors", (ovr_cnt - base_ovr) + (frm_cnt - base_frm), 32'd0);

      // Overrun: output register full, second byte dropped.
      prescale    = 16'd1;
      axis.tready = 1'b0;
      base_q = rx_q.size(); base_ovr = ovr_cnt;
      send_byte(8'h11, 1'b1, 1);
      send_byte(8'h22, 1'b1, 1);
      idle(20);
      check_eq("ovr_tdata", {24'd0, axis.tdata}, 32'h11);
      check_eq("ovr_tvalid", {31'd0, axis.tvalid}, 32'd1);
      check_eq("ovr_pulse", ovr_cnt - base_ovr, 32'd1);
      axis.tready = 1'b1;
      idle(3);
      check_eq("ovr_drain_count", rx_q.size() - base_q, 32'd1);
      if (rx_q.size() > base_q) check_eq("ovr_drain_data", {24'd0, rx_q[base_q]}, 32'h11);
      check_eq("ovr_tvalid_low", {31'd0, axis.tvalid}, 32'd0);

      // Stop bit low: frame error, nothing delivered, line held low as a break.
      base_q = rx_q.size(); base_frm = frm_cnt;
      send_byte(8'h5A, 1'b0, 1);
      idle(30);
      rxd = 1'b1;
      idle(20);
      check_eq("ferr_pulse", frm_cnt - base_frm, 32'd1);
      check_eq("ferr_tvalid", {31'd0, axis.tvalid}, 32'd0);
      check_eq("ferr_count", rx_q.size() - base_q, 32'd0);

      // Start-bit glitch of 2P cycles at prescale=4.
      prescale = 16'd4;
      base_q = rx_q.size(); base_ovr = ovr_cnt; base_frm = frm_cnt; base_busy = busy_rise;
      idle(1);
      rxd = 1'b0;
      idle(8);
      rxd = 1'b1;
      idle(100);
      check_eq("glitch_busy_rise", busy_rise - base_busy, 32'd1);
      check_eq("glitch_busy_low", {31'd0, busy}, 32'd0);
      check_eq("glitch_count", rx_q.size() - base_q, 32'd0);
      check_eq("glitch_errors", (ovr_cnt - base_ovr) + (frm_cnt - base_frm), 32'd0);

      // Reset mid-frame, then a clean frame.
      prescale = 16'd1;
      fork
         send_byte(8'hC3, 1'b1, 1);
         begin
            idle(30);
            rst_n = 1'b0;
            #1;
            check_eq("mid_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
            check_eq("mid_rst_tdata", {24'd0, axis.tdata}, 32'd0);
            check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
            check_eq("mid_rst_overrun", {31'd0, overrun_error}, 32'd0);
            check_eq("mid_rst_frame", {31'd0, frame_error}, 32'd0);
         end
      join
      idle(10);
      rst_n = 1'b1;
      idle(10);
      base_q = rx_q.size();
      send_byte(8'h96, 1'b1, 1);
      idle(20);
      check_eq("post_rst_count", rx_q.size() - base_q, 32'd1);
      if (rx_q.size() > base_q) check_eq("post_rst_data", {24'd0, rx_q[base_q]}, 32'h96);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
